// File: rtl/trisc_sequencer.sv
// trisc_sequencer: instruction-cycle sequencer for the TRISC datapath with memory
// handshake, run/pause, halt/resume, illegal-opcode trap and a retired-instruction counter.
// Optional single-step input: define TRISC_STEP_EN.
module trisc_sequencer #(
  parameter int                      OPC_W      = 3,
  parameter int                      MEM_LAT    = 2,
  parameter logic [OPC_W-1:0]        HALT_OPC   = '1,
  parameter logic [(2**OPC_W)-1:0]   VALID_MASK = '1,
  parameter int                      CNT_W      = 16
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      run,
  input  logic                      resume,
  input  logic                      mem_ready,
  input  logic [OPC_W-1:0]          opcode,
`ifdef TRISC_STEP_EN
  input  logic                      step,
`endif
  output logic                      pc_clr,
  output logic                      mar_ld,
  output logic                      mem_rd,
  output logic                      pc_inc,
  output logic                      ir_ld,
  output logic [(2**OPC_W)-1:0]     ex_en,
  output logic                      halted,
  output logic                      illegal,
  output logic [CNT_W-1:0]          icount,
  output logic [2:0]                state_o
);

  localparam int EX_W = 2**OPC_W;
  localparam int RD_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(MEM_LAT - 1);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;
  localparam logic [2:0] S_IDLE   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             rd_done;
  logic             opc_legal;
  logic             opc_halt;
  logic             step_go;

  assign rd_done   = (rd_cnt_q >= RD_LAST);
  assign opc_legal = VALID_MASK[opcode];
  assign opc_halt  = (opcode == HALT_OPC);

`ifdef TRISC_STEP_EN
  // Only a rising edge of step launches an instruction, so a held step runs one.
  logic step_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign step_go = step & ~step_q;
`else
  assign step_go = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = run ? S_FETCH : S_IDLE;
      S_IDLE:   if (run || step_go) state_d = S_FETCH;
      S_FETCH:  state_d = S_READ;
      S_READ:   if (rd_done && mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // An illegal opcode traps even when it equals HALT_OPC.
        if (!opc_legal) begin
          state_d = S_TRAP;
        end else if (opc_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT:   if (resume) state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
    endcase
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (state_q == S_FETCH) begin
      rd_cnt_d = '0;
    end else if ((state_q == S_READ) && !rd_done) begin
      rd_cnt_d = rd_cnt_q + RD_W'(1);
    end
  end

  always_comb begin
    icount_d = icount_q;
    if ((state_q == S_EXEC) && opc_legal && (icount_q != '1)) begin
      icount_d = icount_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= S_RESET;
      rd_cnt_q <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      icount_q <= icount_d;
    end
  end

  always_comb begin
    pc_clr  = 1'b0;
    mar_ld  = 1'b0;
    mem_rd  = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    ex_en   = '0;
    halted  = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      S_RESET:  pc_clr = 1'b1;
      S_FETCH:  mar_ld = 1'b1;
      S_READ:   mem_rd = 1'b1;
      S_DECODE: begin
        pc_inc = 1'b1;
        ir_ld  = 1'b1;
      end
      S_EXEC: begin
        if (opc_legal && !opc_halt) ex_en = EX_W'(1) << opcode;
      end
      S_HALT:   halted = 1'b1;
      S_TRAP: begin
        halted  = 1'b1;
        illegal = 1'b1;
      end
      S_IDLE:   ;
    endcase
  end

  assign icount  = icount_q;
  assign state_o = state_q;

endmodule

// File: doc/trisc_sequencer.md
# trisc_sequencer

Parametrised instruction-cycle sequencer for the TRISC datapath, the next generation of the fixed eight-state controller. Walks every instruction through reset, fetch, memory read, decode and execute; emits one-hot datapath strobes and a one-hot execute-enable vector indexed by opcode. Adds what the fixed controller lacks:
- variable memory latency with a ready handshake
- run/pause at instruction boundaries
- a halt opcode with resume
- an illegal-opcode trap
- a retired-instruction counter

## Interface
Parameters:
- OPC_W, 3, opcode width; execute vector is 2**OPC_W wide
- MEM_LAT, 2, minimum READ cycles (≥1)
- HALT_OPC, 3'b111, opcode that enters HALT
- VALID_MASK, all ones (2**OPC_W bits), bit n=1 marks opcode n legal
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  sole clock, rising edge
- clear  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = sequence instructions, 0 = park in IDLE at next boundary
- resume  in  1  leaves HALT when high
- mem_ready  in  1  memory data valid
- opcode  in  OPC_W  IR opcode field; valid from the cycle after ir_ld
- pc_clr  out  1  clear PC
- mar_ld  out  1  load MAR from PC
- mem_rd  out  1  memory read strobe
- pc_inc  out  1  increment PC
- ir_ld  out  1  load IR from memory data
- ex_en  out  2**OPC_W  one-hot execute enable, bit = opcode
- halted  out  1  high in HALT or TRAP
- illegal  out  1  high in TRAP
- icount  out  CNT_W  retired instructions, saturating
- state_o  out  3  current state code

## Operation
- State codes: RESET=0, FETCH=1, READ=2, DECODE=3, EXEC=4, HALT=5, TRAP=6, IDLE=7.
- Moore outputs per state:
  - RESET: pc_clr
  - FETCH: mar_ld
  - READ: mem_rd
  - DECODE: pc_inc and ir_ld
  - EXEC: ex_en[opcode], only if legal and not HALT_OPC
  - HALT, TRAP, IDLE: no strobes
- Transitions:
  - RESET → FETCH if run, else IDLE.
  - IDLE → FETCH when run=1.
  - FETCH → READ.
  - READ: stays until rd_cnt ≥ MEM_LAT-1 and mem_ready=1, then → DECODE. rd_cnt clears on READ entry and saturates.
  - DECODE → EXEC.
  - EXEC:
    - if VALID_MASK[opcode]=0 → TRAP; illegal has priority over HALT_OPC.
    - else if opcode==HALT_OPC → HALT.
    - else → FETCH if run, else IDLE.
  - HALT → FETCH when resume=1 (run ignored).
  - TRAP: exited only by clear.
- Every transition is fully specified; no state holds an undefined next state.
- icount increments on each EXEC cycle that leaves to FETCH, IDLE or HALT. It does not increment on TRAP. It holds at all-ones.

## Timing
- Reset (clear low, asynchronous, any state, mid-read included):
  - state=RESET, rd_cnt=0, icount=0
  - pc_clr=1; all other strobes, ex_en, halted and illegal =0
  - state_o=0
- With mem_ready tied high and MEM_LAT=2, an instruction takes 5 cycles: FETCH, READ, READ, DECODE, EXEC.
- Each cycle mem_ready stays low past MEM_LAT-1 adds one READ cycle.
- mem_ready high before MEM_LAT cycles have elapsed is ignored.
- opcode is sampled only in EXEC; changes elsewhere have no effect.
- run dropping mid-instruction completes that instruction before IDLE.
- halted rises on the first HALT/TRAP cycle.

## Configuration
- TRISC_STEP_EN defined:
  - adds input step (1 bit).
  - In IDLE, step=1 with run=0 executes exactly one instruction, then returns to IDLE.
  - run=1 overrides step.
- TRISC_STEP_EN undefined: no step port; IDLE exits only on run.

## Test plan
- Reset: clear low for 2 cycles with run=1, release → state_o 0,1,2,2,3,4,1; pc_clr only in RESET; icount=1 after first EXEC.
- Opcode decode: opcode=3'b010 in EXEC → ex_en=8'b00000100 for exactly 1 cycle; opcode=3'b000 → ex_en=8'b00000001.
- Memory latency: MEM_LAT=2, mem_ready low for 3 extra cycles → mem_rd high 5 cycles, ir_ld on the cycle after mem_ready=1.
- Halt/trap: opcode=3'b111 → HALT, halted=1, icount+1, resume pulse → FETCH. VALID_MASK=8'b01111110 with opcode 0 → TRAP, illegal=1, ex_en=0, icount unchanged, resume ignored.
- Run and reset edge cases: run dropped in READ → instruction completes, then IDLE. clear asserted mid-READ → immediate RESET outputs. CNT_W=4 after 20 instructions → icount=4'hF.
- Single step: TRISC_STEP_EN defined, run=0, one step pulse → exactly one instruction executes, returns to IDLE, icount+1.
